// File: rtl/song_sequencer.sv
// song_sequencer: programmable melody sequencer driving key/key_on into the
// tone generator. Entries {last, rest, note, beats} live in an internal RAM
// that the host writes while idle.
// Optional feature: define SONG_SEQ_TRANSPOSE_EN to add a signed transpose
// input applied (with saturation) to non-rest notes.
module song_sequencer #(
    parameter int NOTE_W     = 4,
    parameter int BEAT_W     = 3,
    parameter int DUR_W      = 26,
    parameter int DEPTH      = 32,
    parameter int GAP_CYCLES = 2500000,
    localparam int AW        = $clog2(DEPTH),
    localparam int EW        = NOTE_W + BEAT_W + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [EW-1:0]     wr_data,
    input  logic              start,
    input  logic [AW-1:0]     start_addr,
    input  logic              loop,
    input  logic              pause,
    input  logic              stop,
    input  logic [DUR_W-1:0]  beat_cycles,
`ifdef SONG_SEQ_TRANSPOSE_EN
    input  logic signed [NOTE_W-1:0] transpose,
`endif
    output logic [NOTE_W-1:0] key,
    output logic              key_on,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     cur_addr
);

    localparam int PW = DUR_W + BEAT_W;
    localparam logic [PW-1:0] GAP_L = PW'(GAP_CYCLES);
    localparam logic [PW-1:0] ONE   = PW'(1);

    typedef struct packed {
        logic              last;
        logic              rest;
        logic [NOTE_W-1:0] note;
        logic [BEAT_W-1:0] beats;
    } entry_t;

    typedef enum logic [1:0] {IDLE, FETCH, NOTE, GAP} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     base, base_nxt, cur_addr_nxt;
    logic [PW-1:0]     cnt, cnt_nxt, gap_len, gap_nxt;
    logic [NOTE_W-1:0] key_nxt, key_f;
    logic              rest_q, rest_nxt, last_q, last_nxt, done_nxt, adv;

    logic [EW-1:0]     mem [DEPTH];
    logic [EW-1:0]     rd_data;
    entry_t            ent;

    logic [BEAT_W-1:0] beats_eff;
    logic [DUR_W-1:0]  bc_eff;
    logic [PW-1:0]     dur, on_len;

    assign ent    = entry_t'(rd_data);
    assign busy   = (state != IDLE);
    assign key_on = (state == NOTE) && !rest_q && !pause;

    // Entry RAM: writes only while idle; the read address is the next
    // cur_addr so the entry is already on rd_data during FETCH.
    always_ff @(posedge clk) begin
        if (wr_en && !busy)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[cur_addr_nxt];
    end

    // Note length split: D = max(beats,1)*max(beat_cycles,1), gap carved off the end.
    always_comb begin
        beats_eff = (ent.beats == '0) ? BEAT_W'(1) : ent.beats;
        bc_eff    = (beat_cycles == '0) ? DUR_W'(1) : beat_cycles;
        dur       = PW'(beats_eff) * PW'(bc_eff);
        on_len    = (dur > GAP_L) ? (dur - GAP_L) : ONE;
    end

`ifdef SONG_SEQ_TRANSPOSE_EN
    logic signed [NOTE_W+1:0] tsum;
    // Transposed key, saturated to the key range; rests keep the raw note.
    always_comb begin
        tsum  = $signed({2'b00, ent.note}) + $signed({{2{transpose[NOTE_W-1]}}, transpose});
        key_f = ent.note;
        if (!ent.rest) begin
            if (tsum < 0)
                key_f = '0;
            else if (tsum > $signed({2'b00, {NOTE_W{1'b1}}}))
                key_f = '1;
            else
                key_f = tsum[NOTE_W-1:0];
        end
    end
`else
    assign key_f = ent.note;
`endif

    // Sequencer next-state: stop beats pause beats normal sequencing.
    always_comb begin
        state_nxt    = state;
        base_nxt     = base;
        cur_addr_nxt = cur_addr;
        cnt_nxt      = cnt;
        gap_nxt      = gap_len;
        key_nxt      = key;
        rest_nxt     = rest_q;
        last_nxt     = last_q;
        done_nxt     = 1'b0;
        adv          = 1'b0;
        if (stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_nxt     = start_addr;
                        cur_addr_nxt = start_addr;
                        state_nxt    = FETCH;
                    end
                end
                FETCH: begin
                    key_nxt   = key_f;
                    rest_nxt  = ent.rest;
                    last_nxt  = ent.last;
                    cnt_nxt   = on_len;
                    gap_nxt   = dur - on_len;
                    state_nxt = NOTE;
                end
                NOTE: begin
                    if (!pause) begin
                        if (cnt <= ONE) begin
                            if (gap_len != '0) begin
                                cnt_nxt   = gap_len;
                                state_nxt = GAP;
                            end else begin
                                adv = 1'b1;
                            end
                        end else begin
                            cnt_nxt = cnt - ONE;
                        end
                    end
                end
                GAP: begin
                    if (!pause) begin
                        if (cnt <= ONE) adv = 1'b1;
                        else            cnt_nxt = cnt - ONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
            if (adv) begin
                if (!last_q) begin
                    cur_addr_nxt = cur_addr + AW'(1);
                    state_nxt    = FETCH;
                end else if (loop) begin
                    cur_addr_nxt = base;
                    state_nxt    = FETCH;
                end else begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base     <= '0;
            cur_addr <= '0;
            cnt      <= '0;
            gap_len  <= '0;
            key      <= '0;
            rest_q   <= 1'b0;
            last_q   <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            base     <= base_nxt;
            cur_addr <= cur_addr_nxt;
            cnt      <= cnt_nxt;
            gap_len  <= gap_nxt;
            key      <= key_nxt;
            rest_q   <= rest_nxt;
            last_q   <= last_nxt;
            done     <= done_nxt;
        end
    end

endmodule
